// File: rtl/normhw_ctrl_pkg.sv
// normhw_ctrl_pkg: shared constants for the normhw frame controller.
// Register map, FSM states and drop counter saturation value.
package normhw_ctrl_pkg;

  localparam logic [31:0] ADDR_CTRL        = 32'd0;
  localparam logic [31:0] ADDR_STATUS      = 32'd1;
  localparam logic [31:0] ADDR_FRAME_CNT   = 32'd2;
  localparam logic [31:0] ADDR_SHADOW_BASE = 32'd4;

  localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPDATE = 2'd1,
    S_STREAM = 2'd2,
    S_DROP   = 2'd3
  } state_t;

endpackage

// File: rtl/normhw_ctrl_regs.sv
// normhw_ctrl_regs: host slave register file.
// Holds CTRL, the SHADOW bank, the pending flag and the read mux.
module normhw_ctrl_regs
  import normhw_ctrl_pkg::*;
#(
  parameter int NREG       = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_proc,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr_rel_i,
  input  logic                  wr_i,
  input  logic [31:0]           datawr_i,
  input  logic                  rd_i,
  output logic [31:0]           datard_o,
  input  logic                  upd_start,
  input  logic                  streaming,
  input  logic [15:0]           drop_cnt,
  input  logic [31:0]           frame_cnt,
  output logic                  enable,
  output logic                  pending,
  output logic [NREG-1:0][31:0] shadow
);

  logic [31:0]     addr;
  logic [NREG-1:0] sh_hit;
  logic            sh_wr;
  logic [31:0]     rd_mux;

  assign addr  = 32'(addr_rel_i);
  assign sh_wr = wr_i & (|sh_hit);

  // Decode which shadow slot the host address selects
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      sh_hit[i] = (addr == ADDR_SHADOW_BASE + 32'(i));
    end
  end

  // Read mux; unmapped addresses return zero
  always_comb begin
    rd_mux = '0;
    if (addr == ADDR_CTRL)
      rd_mux = {31'd0, enable};
    else if (addr == ADDR_STATUS)
      rd_mux = {drop_cnt, 14'd0, streaming, pending};
    else if (addr == ADDR_FRAME_CNT)
      rd_mux = frame_cnt;
    for (int i = 0; i < NREG; i++) begin
      if (sh_hit[i]) rd_mux = shadow[i];
    end
  end

  // Host writes, pending tracking and registered read data
  always_ff @(posedge clk_proc) begin
    if (reset) begin
      enable   <= 1'b0;
      pending  <= 1'b0;
      shadow   <= '0;
      datard_o <= '0;
    end else begin
      if (wr_i && addr == ADDR_CTRL) enable <= datawr_i[0];
      for (int i = 0; i < NREG; i++) begin
        if (wr_i && sh_hit[i]) shadow[i] <= datawr_i;
      end
      // a write racing the update start must not be lost
      if (sh_wr)          pending <= 1'b1;
      else if (upd_start) pending <= 1'b0;
      datard_o <= rd_i ? rd_mux : '0;
    end
  end

endmodule

// File: rtl/normhw_ctrl.sv
// normhw_ctrl: whole-frame gate and blanking-time config push for normhw.
// Macro NORMHW_CTRL_STATS_EN enables the frame and drop counters.
module normhw_ctrl
  import normhw_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NREG       = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_proc,
  input  logic                  reset,
  input  logic                  in_fv,
  input  logic                  in_dv,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_fv,
  output logic                  out_dv,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic [ADDR_WIDTH-1:0] addr_rel_i,
  input  logic                  wr_i,
  input  logic [31:0]           datawr_i,
  input  logic                  rd_i,
  output logic [31:0]           datard_o,
  output logic [ADDR_WIDTH-1:0] m_addr_o,
  output logic                  m_wr_o,
  output logic [31:0]           m_data_o
);

  localparam int CW = (NREG > 1) ? $clog2(NREG) : 1;

  state_t               state, state_n;
  logic                 fv_d;
  logic                 late;
  logic [CW-1:0]        upd_cnt;
  logic                 enable, pending;
  logic [NREG-1:0][31:0] shadow;
  logic                 rise, fall, upd_last, upd_start;
  logic [15:0]          drop_cnt;
  logic [31:0]          frame_cnt;

  assign rise      = in_fv & ~fv_d;
  assign fall      = ~in_fv & fv_d;
  assign upd_last  = (upd_cnt == CW'(NREG - 1));
  assign upd_start = (state == S_IDLE) && (state_n == S_UPDATE);

  normhw_ctrl_regs #(
    .NREG       (NREG),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_regs (
    .clk_proc   (clk_proc),
    .reset      (reset),
    .addr_rel_i (addr_rel_i),
    .wr_i       (wr_i),
    .datawr_i   (datawr_i),
    .rd_i       (rd_i),
    .datard_o   (datard_o),
    .upd_start  (upd_start),
    .streaming  (state == S_STREAM),
    .drop_cnt   (drop_cnt),
    .frame_cnt  (frame_cnt),
    .enable     (enable),
    .pending    (pending),
    .shadow     (shadow)
  );

  // Next-state: frame start beats a pending update in IDLE
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (rise)                 state_n = enable ? S_STREAM : S_DROP;
        else if (pending && !in_fv) state_n = S_UPDATE;
      end
      S_UPDATE: begin
        if (upd_last) state_n = (late || in_fv) ? S_DROP : S_IDLE;
      end
      S_STREAM: begin
        if (fall) state_n = S_IDLE;
      end
      S_DROP: begin
        if (!in_fv) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, edge history, update slot counter and late-frame flag
  always_ff @(posedge clk_proc) begin
    if (reset) begin
      state   <= S_DROP;
      fv_d    <= 1'b1;
      late    <= 1'b0;
      upd_cnt <= '0;
    end else begin
      state <= state_n;
      fv_d  <= in_fv;
      if (upd_start) begin
        late    <= 1'b0;
        upd_cnt <= '0;
      end else if (state == S_UPDATE) begin
        if (rise) late <= 1'b1;
        upd_cnt <= upd_last ? '0 : upd_cnt + 1'b1;
      end
    end
  end

  // Register push into normhw, only while updating
  assign m_wr_o   = (state == S_UPDATE);
  assign m_addr_o = m_wr_o ? ADDR_WIDTH'(upd_cnt) : '0;
  assign m_data_o = m_wr_o ? shadow[upd_cnt] : '0;

  // Stream gate: looking at next state keeps latency at one cycle
  always_ff @(posedge clk_proc) begin
    if (reset) begin
      out_fv   <= 1'b0;
      out_dv   <= 1'b0;
      out_data <= '0;
    end else begin
      out_fv <= (state_n == S_STREAM) & in_fv;
      out_dv <= (state_n == S_STREAM) & in_fv & in_dv;
      if (in_dv) out_data <= in_data;
    end
  end

`ifdef NORMHW_CTRL_STATS_EN
  logic drop_enter;

  assign drop_enter = (state != S_DROP) && (state_n == S_DROP);

  // Passed-frame counter wraps, drop counter saturates
  always_ff @(posedge clk_proc) begin
    if (reset) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (state == S_STREAM && fall) frame_cnt <= frame_cnt + 32'd1;
      if (drop_enter && drop_cnt != DROP_CNT_MAX)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  assign frame_cnt = '0;
  assign drop_cnt  = '0;
`endif

endmodule

// File: doc/normhw_ctrl.md
# normhw_ctrl

Frame-level controller placed directly upstream of the `normhw` normalisation process. It gates the 16-bit pixel stream so that only whole frames reach `normhw`, and it holds host-written shadow configuration. Configuration is pushed into `normhw` over its register port only during vertical blanking, so parameters never change mid-frame. It also counts passed and dropped frames for host diagnostics.

## Interface
Parameters:
- `DATA_WIDTH`, 16: pixel width.
- `NREG`, 4: number of shadowed `normhw` registers, 1..8.
- `ADDR_WIDTH`, 4: host and master address width.

Ports:
- `clk_proc`  in  1  processing clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_fv`  in  1  upstream frame valid.
- `in_dv`  in  1  upstream data valid.
- `in_data`  in  `DATA_WIDTH`  upstream pixel.
- `out_fv`  out  1  frame valid to `normhw`.
- `out_dv`  out  1  data valid to `normhw`.
- `out_data`  out  `DATA_WIDTH`  pixel to `normhw`.
- `addr_rel_i`  in  `ADDR_WIDTH`  host register address.
- `wr_i`  in  1  host write strobe.
- `datawr_i`  in  32  host write data.
- `rd_i`  in  1  host read strobe.
- `datard_o`  out  32  host read data.
- `m_addr_o`  out  `ADDR_WIDTH`  register address driven into `normhw`.
- `m_wr_o`  out  1  write strobe driven into `normhw`.
- `m_data_o`  out  32  write data driven into `normhw`.

## Operation
Host register map:
- 0 CTRL (rw): bit0 `enable`.
- 1 STATUS (ro): bit0 `pending`, bit1 `streaming`, bits[31:16] `drop_cnt`.
- 2 FRAME_CNT (ro).
- 4..4+NREG-1 SHADOW[i] (rw).
- Unmapped addresses read 0 and ignore writes.

Shadow and pending rules:
- Any write to a SHADOW register sets `pending`.
- Entering UPDATE clears `pending`.
- A SHADOW write during UPDATE sets `pending` again, so another UPDATE pass follows.

Control FSM:
- IDLE: `in_fv` rising edge (`in_fv & ~fv_d`) goes to STREAM if `enable`, else DROP. Otherwise, `pending & ~in_fv` goes to UPDATE. If a rising edge and `pending` occur in the same cycle, the frame start wins and the update waits for the next blanking.
- UPDATE: lasts exactly NREG cycles. In cycle k, `m_wr_o`=1, `m_addr_o`=k, `m_data_o`=SHADOW[k] as read that cycle. An `in_fv` rising edge during UPDATE sets `late`. On completion, go to DROP if `late` or `in_fv`, else IDLE.
- STREAM: pass pixels through. `in_fv` falling edge: increment FRAME_CNT, go to IDLE.
- DROP: hold outputs low. Go to IDLE once `in_fv`=0. On entry from IDLE or UPDATE, increment `drop_cnt`, saturating at 0xFFFF.

Stream gating:
- `out_fv` = `in_fv` registered while in STREAM.
- `out_dv` = `in_dv & in_fv` registered while in STREAM.
- `out_data` is registered from `in_data` whenever `in_dv`; it holds otherwise.
- A mid-frame change to `enable` takes effect at the next frame.
- FRAME_CNT wraps at 2^32.

Reset:
- FSM enters DROP; `fv_d`=1, so a frame already in progress is never seen as a rising edge.
- All outputs reset to 0; CTRL=0, SHADOW=0, `pending`=0, both counters 0.
- A reset mid-frame drops the remainder of that frame.

## Timing
- Stream latency: exactly 1 cycle, in_* to out_*.
- On a STREAM start, `out_fv` rises one cycle after `in_fv`.
- `out_fv` falls one cycle after `in_fv` falls.
- Host writes take effect at the next edge. `datard_o` is valid 1 cycle after `rd_i`; otherwise 0.
- UPDATE starts one cycle after `pending` is seen in IDLE with `in_fv`=0, and lasts NREG consecutive `m_wr_o` cycles.
- `streaming` = (state==STREAM).

## Configuration
Macro `NORMHW_CTRL_STATS_EN`:
- Defined: FRAME_CNT and `drop_cnt` are implemented as described.
- Undefined: both counters are removed. FRAME_CNT and STATUS[31:16] read 0. Gating and drop behaviour are unchanged.

## Structure
- Package `normhw_ctrl_pkg`: register address constants (CTRL, STATUS, FRAME_CNT, SHADOW_BASE), state enum {IDLE, UPDATE, STREAM, DROP}, and the `drop_cnt` saturation constant.
- Sub-module `normhw_ctrl_regs`: host slave register file containing CTRL, SHADOW, `pending` and the read mux. The top level holds the FSM, stream gating and counters.

## Test plan
- Reset, then host writes CTRL=1, then a 64-pixel frame → output identical to input, delayed 1 cycle; FRAME_CNT=1; `drop_cnt`=0.
- CTRL=0, frame → `out_fv`/`out_dv` stay 0 for the whole frame; `drop_cnt`=1. Set CTRL=1 mid-frame → still dropped; the next frame passes.
- Write SHADOW[2]=0x1234 mid-frame → no `m_wr_o` until `in_fv` falls, then exactly 4 cycles with `m_addr_o`=0..3, carrying 0x1234 at `m_addr_o`=2; `pending` then reads 0.
- `in_fv` rises during cycle 2 of UPDATE → UPDATE completes all 4 writes; the frame is dropped; `drop_cnt`+1.
- SHADOW write during UPDATE → a second 4-cycle UPDATE pass runs in the following blanking.
- Assert `reset` mid-frame, release while `in_fv`=1 → no `out_fv` until the next rising edge; the following frame passes.
